ahb_mem_sequencer: RTL and testbench

AHB_MEM_SEQUENCER -- requirements
Module: ahb_mem_sequencer

---
 rtl/ahb_pkg.sv | 22 ++
 rtl/ahb_mem_sequencer_if.sv | 26 ++
 rtl/mem_req_arb.sv | 21 ++
 rtl/ahb_mem_sequencer.sv | 129 ++++++++++++
 tb/tb_ahb_mem_sequencer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-lite encodings and sequencer state types
// Purpose: transfer-type/size encodings, FSM state enum and requester id
// used by the memory sequencer and its arbiter. No ports.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ADDR     = 2'd1,
    DATA     = 2'd2,
    MISALIGN = 2'd3
  } seq_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

endpackage

// File: rtl/ahb_mem_sequencer_if.sv
// rtl/ahb_mem_sequencer_if.sv - AHB-lite single-master bus bundle
// Purpose: groups the AHB-lite address/data/response signals.
// Modports: master drives HADDR/HTRANS/HWRITE/HSIZE/HWDATA and samples
// HRDATA/HREADY/HRESP; slave is the mirror image.
interface ahb_mem_sequencer_if;

  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    output HRDATA, HREADY, HRESP
  );

endinterface

// File: rtl/mem_req_arb.sv
// rtl/mem_req_arb.sv - two-requester arbiter with contention alternation
// Purpose: picks fetch or load/store. Load/store wins by default; when both
// request and load/store won the previous contended round, fetch wins.
// Ports: if_req, ls_req (requests), last_ls (ls won last contended round),
// grant (some requester selected), owner (selected requester).
module mem_req_arb
  import ahb_pkg::*;
(
  input  logic   if_req,
  input  logic   ls_req,
  input  logic   last_ls,
  output logic   grant,
  output owner_e owner
);

  always_comb begin
    grant = if_req | ls_req;
    owner = (ls_req && !(if_req && last_ls)) ? OWN_LS : OWN_IF;
  end

endmodule

// File: rtl/ahb_mem_sequencer.sv
// rtl/ahb_mem_sequencer.sv - sequences fetch and load/store requests onto AHB-lite
// Purpose: arbitrates two requesters, issues one single-word NONSEQ transfer
// per request, returns a one-cycle done/err pulse and registered read data.
// Misaligned addresses never reach the bus and complete with err.
// Ports: clk, rst_n (async active-low); if_* fetch requester (read-only);
// ls_* load/store requester; bus (AHB-lite master); busy (not IDLE).
module ahb_mem_sequencer
  import ahb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 if_req,
  input  logic [31:0]          if_addr,
  output logic                 if_done,
  output logic                 if_err,
  output logic [31:0]          if_rdata,
  input  logic                 ls_req,
  input  logic                 ls_write,
  input  logic [31:0]          ls_addr,
  input  logic [31:0]          ls_wdata,
  output logic                 ls_done,
  output logic                 ls_err,
  output logic [31:0]          ls_rdata,
  ahb_mem_sequencer_if.master  bus,
  output logic                 busy
);

  seq_state_e  state_q, state_d;
  owner_e      owner_q, arb_owner;
  logic        arb_grant;
  logic        last_ls_q;
  logic        wr_q;
  logic [31:0] haddr_q;
  logic [31:0] wdata_q;
  logic [31:0] sel_addr;
  logic        sel_write;

  mem_req_arb u_arb (
    .if_req  (if_req),
    .ls_req  (ls_req),
    .last_ls (last_ls_q),
    .grant   (arb_grant),
    .owner   (arb_owner)
  );

  assign sel_addr  = (arb_owner == OWN_LS) ? ls_addr : if_addr;
  assign sel_write = (arb_owner == OWN_LS) & ls_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (arb_grant) state_d = (sel_addr[1:0] != 2'b00) ? MISALIGN : ADDR;
      ADDR:     if (bus.HREADY) state_d = DATA;
      DATA:     if (bus.HREADY) state_d = IDLE;
      MISALIGN: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Bus control decodes from state plus the latched write flag only.
  always_comb begin
    bus.HTRANS = (state_q == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    bus.HWRITE = (state_q == ADDR) & wr_q;
    busy       = (state_q != IDLE);
  end

  assign bus.HSIZE  = HSIZE_WORD;
  assign bus.HADDR  = haddr_q;
  assign bus.HWDATA = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q   <= OWN_IF;
      last_ls_q <= 1'b0;
      wr_q      <= 1'b0;
      haddr_q   <= '0;
      wdata_q   <= '0;
      if_done   <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= '0;
      ls_done   <= 1'b0;
      ls_err    <= 1'b0;
      ls_rdata  <= '0;
    end else begin
      if_done <= 1'b0;
      if_err  <= 1'b0;
      ls_done <= 1'b0;
      ls_err  <= 1'b0;
      case (state_q)
        IDLE: if (arb_grant) begin
          owner_q <= arb_owner;
          wr_q    <= sel_write;
          wdata_q <= (arb_owner == OWN_LS) ? ls_wdata : '0;
          // HADDR only moves for transfers that actually go on the bus.
          if (sel_addr[1:0] == 2'b00) haddr_q <= sel_addr;
          // Alternation memory only changes on contended rounds.
          if (if_req && ls_req) last_ls_q <= (arb_owner == OWN_LS);
        end
        DATA: if (bus.HREADY) begin
          if (owner_q == OWN_LS) begin
            ls_done <= 1'b1;
            ls_err  <= bus.HRESP;
            if (!wr_q && !bus.HRESP) ls_rdata <= bus.HRDATA;
          end else begin
            if_done <= 1'b1;
            if_err  <= bus.HRESP;
            if (!bus.HRESP) if_rdata <= bus.HRDATA;
          end
        end
        MISALIGN: begin
          if (owner_q == OWN_LS) begin
            ls_done <= 1'b1;
            ls_err  <= 1'b1;
          end else begin
            if_done <= 1'b1;
            if_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_mem_sequencer.sv
// tb/tb_ahb_mem_sequencer.sv - directed self-checking bench for ahb_mem_sequencer
module tb_ahb_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, ls_req, ls_write;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic        if_done, if_err, ls_done, ls_err, busy;
  logic [31:0] if_rdata, ls_rdata;
  int          total = 0;
  int          bad = 0;

  ahb_mem_sequencer_if bus ();

  ahb_mem_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_done  (if_done),
    .if_err   (if_err),
    .if_rdata (if_rdata),
    .ls_req   (ls_req),
    .ls_write (ls_write),
    .ls_addr  (ls_addr),
    .ls_wdata (ls_wdata),
    .ls_done  (ls_done),
    .ls_err   (ls_err),
    .ls_rdata (ls_rdata),
    .bus      (bus),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    if_req = 0; ls_req = 0; ls_write = 0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0;
    bus.HRDATA = 0; bus.HREADY = 1; bus.HRESP = 0;
    #22;
    chk("rst_htrans", bus.HTRANS, 2'b00);
    chk("rst_hwrite", bus.HWRITE, 0);
    chk("rst_haddr", bus.HADDR, 0);
    chk("rst_hwdata", bus.HWDATA, 0);
    chk("rst_hsize", bus.HSIZE, 3'b010);
    chk("rst_busy", busy, 0);
    chk("rst_done", {if_done, if_err, ls_done, ls_err}, 0);
    chk("rst_rdata", if_rdata | ls_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait read by load/store
    ls_req = 1; ls_write = 0; ls_addr = 32'h100; bus.HRDATA = 32'hDEADBEEF;
    tick();
    chk("rd_addr_htrans", bus.HTRANS, 2'b10);
    chk("rd_addr_haddr", bus.HADDR, 32'h100);
    chk("rd_addr_hwrite", bus.HWRITE, 0);
    chk("rd_addr_busy", busy, 1);
    tick();
    chk("rd_data_htrans", bus.HTRANS, 2'b00);
    chk("rd_data_nodone", ls_done, 0);
    tick();
    chk("rd_done", ls_done, 1);
    chk("rd_err", ls_err, 0);
    chk("rd_rdata", ls_rdata, 32'hDEADBEEF);
    chk("rd_if_quiet", {if_done, if_err}, 0);
    ls_req = 0;
    tick();
    chk("rd_done_pulse", ls_done, 0);
    chk("rd_idle_busy", busy, 0);

    // Write with two wait states in DATA
    ls_req = 1; ls_write = 1; ls_addr = 32'h200; ls_wdata = 32'h12345678;
    bus.HRDATA = 32'hBAD0BAD0;
    tick();
    chk("wr_addr_hwrite", bus.HWRITE, 1);
    chk("wr_addr_htrans", bus.HTRANS, 2'b10);
    chk("wr_addr_haddr", bus.HADDR, 32'h200);
    tick();
    chk("wr_data_hwrite", bus.HWRITE, 0);
    chk("wr_data_hwdata0", bus.HWDATA, 32'h12345678);
    bus.HREADY = 0;
    tick();
    chk("wr_wait1_hwdata", bus.HWDATA, 32'h12345678);
    chk("wr_wait1_done", ls_done, 0);
    chk("wr_wait1_htrans", bus.HTRANS, 2'b00);
    tick();
    chk("wr_wait2_hwdata", bus.HWDATA, 32'h12345678);
    chk("wr_wait2_done", ls_done, 0);
    bus.HREADY = 1;
    tick();
    chk("wr_done", ls_done, 1);
    chk("wr_err", ls_err, 0);
    chk("wr_rdata_kept", ls_rdata, 32'hDEADBEEF);
    ls_req = 0; ls_write = 0;
    tick();

    // Contention: both held for four transfers, expect ls, if, ls, if
    if_req = 1; if_addr = 32'h400;
    ls_req = 1; ls_addr = 32'h500;
    for (int i = 0; i < 4; i++) begin
      bus.HRDATA = 32'h1000 + i;
      tick();
      chk($sformatf("arb_haddr%0d", i), bus.HADDR, (i % 2 == 0) ? 32'h500 : 32'h400);
      tick();
      tick();
      chk($sformatf("arb_done%0d", i), {if_done, ls_done}, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i == 3) begin
        if_req = 0; ls_req = 0;
      end
    end
    chk("arb_ls_rdata", ls_rdata, 32'h1002);
    chk("arb_if_rdata", if_rdata, 32'h1003);
    tick();

    // Misaligned load/store skips the bus
    ls_req = 1; ls_addr = 32'h103;
    tick();
    chk("mis_htrans", bus.HTRANS, 2'b00);
    chk("mis_busy", busy, 1);
    chk("mis_nodone", ls_done, 0);
    tick();
    chk("mis_done_err", {ls_done, ls_err}, 2'b11);
    chk("mis_haddr_kept", bus.HADDR, 32'h400);
    ls_req = 0;
    tick();
    chk("mis_pulse", {ls_done, ls_err}, 2'b00);

    // Fetch read with two-cycle error response
    if_req = 1; if_addr = 32'h0;
    tick();
    chk("err_addr_haddr", bus.HADDR, 32'h0);
    chk("err_addr_htrans", bus.HTRANS, 2'b10);
    tick();
    bus.HRESP = 1; bus.HREADY = 0; bus.HRDATA = 32'hFFFFFFFF;
    tick();
    chk("err_wait_done", if_done, 0);
    bus.HREADY = 1;
    tick();
    chk("err_done_err", {if_done, if_err}, 2'b11);
    chk("err_rdata_kept", if_rdata, 32'h1003);
    chk("err_ls_quiet", {ls_done, ls_err}, 2'b00);
    if_req = 0; bus.HRESP = 0;
    tick();

    // Asynchronous reset in DATA with HREADY low
    ls_req = 1; ls_addr = 32'h300; bus.HRDATA = 32'h55AA55AA;
    tick();
    tick();
    bus.HREADY = 0;
    tick();
    chk("ar_busy_before", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_htrans", bus.HTRANS, 2'b00);
    chk("ar_haddr", bus.HADDR, 0);
    chk("ar_ls_rdata", ls_rdata, 0);
    ls_req = 0;
    @(negedge clk);
    bus.HREADY = 1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("ar_nodone%0d", i), {if_done, ls_done, busy}, 3'b000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
